// File: rtl/arbiter_rr.sv
// N-requester bus arbiter: fixed-priority or round-robin selection, grants held
// until release or an optional hold timeout, with a mandatory idle cycle between grants.
module arbiter_rr #(
   parameter int N        = 5,
   parameter int RR       = 0,
   parameter int MAX_HOLD = 0,
   parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic           preempt
);

   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
   localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state, state_nx;
   logic [IDW-1:0] owner, owner_nx;
   logic [IDW-1:0] ptr, ptr_nx;
   logic [IDW-1:0] excl_id, excl_id_nx;
   logic           excl, excl_nx;
   logic           preempt_nx;
   logic [HW-1:0]  hold_cnt, hold_nx;

   logic [N-1:0]   excl_mask, cand;
   logic [IDW-1:0] start, win, next_ptr;

   // Circular search from start; first asserted candidate wins.
   function automatic logic [IDW-1:0] pick(input logic [N-1:0] c, input logic [IDW-1:0] s);
      logic [IDW-1:0] w;
      logic           hit;
      int             idx;
      w   = '0;
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(s) + i) % N;
         if (!hit && c[idx]) begin
            w   = IDW'(idx);
            hit = 1'b1;
         end
      end
      return w;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         excl_id  <= '0;
         excl     <= 1'b0;
         preempt  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         ptr      <= ptr_nx;
         excl_id  <= excl_id_nx;
         excl     <= excl_nx;
         preempt  <= preempt_nx;
         hold_cnt <= hold_nx;
      end
   end

   always_comb begin
      // A timed-out requester sits out one arbitration unless nobody else wants the bus.
      excl_mask = N'(1) << excl_id;
      cand      = req;
      if (excl && ((req & ~excl_mask) != '0))
         cand = req & ~excl_mask;
      start    = (RR != 0 && N > 1) ? ptr : '0;
      win      = pick(cand, start);
      next_ptr = (owner == LAST_ID) ? '0 : owner + IDW'(1);

      state_nx   = state;
      owner_nx   = owner;
      ptr_nx     = ptr;
      excl_id_nx = excl_id;
      excl_nx    = excl;
      preempt_nx = 1'b0;
      hold_nx    = hold_cnt;

      case (state)
         IDLE: begin
            if (req != '0) begin
               state_nx = GRANT;
               owner_nx = win;
               hold_nx  = '0;
               excl_nx  = 1'b0;
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               state_nx = IDLE;
               ptr_nx   = next_ptr;
               hold_nx  = '0;
            end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
               state_nx   = IDLE;
               ptr_nx     = next_ptr;
               hold_nx    = '0;
               preempt_nx = 1'b1;
               excl_nx    = 1'b1;
               excl_id_nx = owner;
            end else if (MAX_HOLD != 0) begin
               hold_nx = hold_cnt + HW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      grant_id    = '0;
      if (state == GRANT) begin
         grant[owner] = 1'b1;
         grant_valid  = 1'b1;
         grant_id     = owner;
      end
   end

endmodule
